// File: rtl/wkup_cdb_arb_pkg.sv
// rtl/wkup_cdb_arb_pkg.sv - shared ROB id / result word types and wakeup bus widths
package wkup_cdb_arb_pkg;

    localparam int ROB_ID_W       = 6;
    localparam int WORD_W         = 32;
    localparam int SRC_COUNT_DEF  = 4;
    localparam int CDB_COUNT_DEF  = 2;
    localparam int FIFO_DEPTH_DEF = 2;

    typedef logic [ROB_ID_W-1:0] rob_id_t;
    typedef logic [WORD_W-1:0]   word_t;

    typedef struct packed {
        rob_id_t rid;
        word_t   data;
    } cdb_pack_t;

endpackage

// File: rtl/wkup_src_fifo.sv
// rtl/wkup_src_fifo.sv - per-producer result buffer, power-of-two depth
module wkup_src_fifo
    import wkup_cdb_arb_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    input  logic      push_i,
    input  cdb_pack_t push_data_i,
    input  logic      pop_i,
    output cdb_pack_t head_o,
    output logic      empty_o,
    output logic      full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    cdb_pack_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/wkup_cdb_arb.sv
// rtl/wkup_cdb_arb.sv - round-robin arbiter of producer results onto wakeup broadcast channels
module wkup_cdb_arb
    import wkup_cdb_arb_pkg::*;
#(
    parameter int SRC_COUNT  = SRC_COUNT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int CDB_COUNT  = CDB_COUNT_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [SRC_COUNT-1:0]           src_valid_i,
    input  rob_id_t [SRC_COUNT-1:0]        src_rid_i,
    input  word_t [SRC_COUNT-1:0]          src_data_i,
    output logic [SRC_COUNT-1:0]           src_ready_o,
    output logic [CDB_COUNT-1:0]           wkup_valid_o,
    output rob_id_t [CDB_COUNT-1:0]        wkup_rid_o,
    output word_t [CDB_COUNT-1:0]          wkup_data_o
);

    localparam int SRC_IDX_W = (SRC_COUNT > 1) ? $clog2(SRC_COUNT) : 1;

    cdb_pack_t                   push_pack [SRC_COUNT];
    cdb_pack_t                   head      [SRC_COUNT];
    logic [SRC_COUNT-1:0]        empty;
    logic [SRC_COUNT-1:0]        full;
    logic [SRC_COUNT-1:0]        pop;

    logic [SRC_IDX_W-1:0]        rr_q, rr_d;
    logic [CDB_COUNT-1:0]        wkup_valid_q, wkup_valid_d;
    cdb_pack_t [CDB_COUNT-1:0]   wkup_q, wkup_d;
    int                          nsel;
    int                          last;
    int                          idx;

    for (genvar s = 0; s < SRC_COUNT; s++) begin : g_src
        assign push_pack[s]   = '{rid: src_rid_i[s], data: src_data_i[s]};
        assign src_ready_o[s] = ~full[s];

        wkup_src_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk         (clk),
            .rst         (rst),
            .flush       (flush),
            .push_i      (src_valid_i[s] & ~full[s]),
            .push_data_i (push_pack[s]),
            .pop_i       (pop[s]),
            .head_o      (head[s]),
            .empty_o     (empty[s]),
            .full_o      (full[s])
        );
    end

    // Walk sources from rr_q; the n-th non-empty head found goes to channel n.
    always_comb begin
        pop          = '0;
        wkup_valid_d = '0;
        wkup_d       = wkup_q;
        nsel         = 0;
        last         = 0;
        idx          = 0;
        for (int k = 0; k < SRC_COUNT; k++) begin
            idx = (int'(rr_q) + k) % SRC_COUNT;
            for (int s = 0; s < SRC_COUNT; s++) begin
                if (s == idx && !empty[s] && nsel < CDB_COUNT) begin
                    pop[s] = 1'b1;
                    for (int c = 0; c < CDB_COUNT; c++) begin
                        if (c == nsel) begin
                            wkup_valid_d[c] = 1'b1;
                            wkup_d[c]       = head[s];
                        end
                    end
                    nsel = nsel + 1;
                    last = s;
                end
            end
        end
        rr_d = (nsel > 0) ? SRC_IDX_W'((last + 1) % SRC_COUNT) : rr_q;
    end

    // Idle channels keep their last rid/data so the broadcast bus does not toggle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wkup_valid_q <= '0;
            wkup_q       <= '0;
            rr_q         <= '0;
        end else if (flush) begin
            wkup_valid_q <= '0;
            rr_q         <= '0;
        end else begin
            wkup_valid_q <= wkup_valid_d;
            wkup_q       <= wkup_d;
            rr_q         <= rr_d;
        end
    end

    assign wkup_valid_o = wkup_valid_q;
    for (genvar c = 0; c < CDB_COUNT; c++) begin : g_out
        assign wkup_rid_o[c]  = wkup_q[c].rid;
        assign wkup_data_o[c] = wkup_q[c].data;
    end

endmodule

// File: tb/tb_wkup_cdb_arb.sv
// tb/tb_wkup_cdb_arb.sv - self-checking bench for wkup_cdb_arb
module tb_wkup_cdb_arb;
    import wkup_cdb_arb_pkg::*;

    localparam int NS = 4;
    localparam int NC = 2;
    localparam int D  = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic [NS-1:0]      src_valid_i;
    rob_id_t [NS-1:0]   src_rid_i;
    word_t [NS-1:0]     src_data_i;
    logic [NS-1:0]      src_ready_o;
    logic [NC-1:0]      wkup_valid_o;
    rob_id_t [NC-1:0]   wkup_rid_o;
    word_t [NC-1:0]     wkup_data_o;

    wkup_cdb_arb #(
        .SRC_COUNT  (NS),
        .FIFO_DEPTH (D),
        .CDB_COUNT  (NC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .src_valid_i  (src_valid_i),
        .src_rid_i    (src_rid_i),
        .src_data_i   (src_data_i),
        .src_ready_o  (src_ready_o),
        .wkup_valid_o (wkup_valid_o),
        .wkup_rid_o   (wkup_rid_o),
        .wkup_data_o  (wkup_data_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one queue per source, a round-robin start index, expected outputs.
    logic [5:0]  mq_rid  [NS][$];
    logic [31:0] mq_data [NS][$];
    int          mrr = 0;
    logic [NC-1:0] mv = '0;
    logic [5:0]  mrid  [NC];
    logic [31:0] mdata [NC];
    bit          init_done = 0;

    typedef struct packed {
        logic              r;
        logic              f;
        logic [3:0]        v;
        logic [3:0][5:0]   rid;
        logic [3:0][31:0]  dat;
        logic [1:0]        ev;
        logic [5:0]        erid0;
        logic [31:0]       edat0;
        logic [5:0]        erid1;
        logic [31:0]       edat1;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < NS; s++) begin
            mq_rid[s].delete();
            mq_data[s].delete();
        end
        mrr = 0;
        mv  = '0;
    endtask

    task automatic step(input logic r, input logic f, input logic [3:0] v,
                        input logic [3:0][5:0] rid, input logic [3:0][31:0] dat);
        logic [3:0] rdy;
        int n;
        int last;
        int s;
        rst = r; flush = f; src_valid_i = v; src_rid_i = rid; src_data_i = dat;
        for (int i = 0; i < NS; i++) rdy[i] = (mq_rid[i].size() < D);
        if (init_done) check("src_ready", 64'(src_ready_o), 64'(rdy));
        @(posedge clk);
        if (r) begin
            model_clear();
            for (int c = 0; c < NC; c++) begin
                mrid[c]  = '0;
                mdata[c] = '0;
            end
            init_done = 1;
        end else if (f) begin
            model_clear();
        end else begin
            n = 0; last = 0; mv = '0;
            for (int k = 0; k < NS; k++) begin
                s = (mrr + k) % NS;
                if (mq_rid[s].size() > 0 && n < NC) begin
                    for (int c = 0; c < NC; c++) begin
                        if (c == n) begin
                            mv[c]    = 1'b1;
                            mrid[c]  = mq_rid[s].pop_front();
                            mdata[c] = mq_data[s].pop_front();
                        end
                    end
                    n++;
                    last = s;
                end
            end
            if (n > 0) mrr = (last + 1) % NS;
            for (int i = 0; i < NS; i++) begin
                if (v[i] && rdy[i]) begin
                    mq_rid[i].push_back(rid[i]);
                    mq_data[i].push_back(dat[i]);
                end
            end
        end
        #1;
        check("wkup_valid", 64'(wkup_valid_o), 64'(mv));
        for (int c = 0; c < NC; c++) begin
            check("wkup_rid", 64'(wkup_rid_o[c]), 64'(mrid[c]));
            check("wkup_data", 64'(wkup_data_o[c]), 64'(mdata[c]));
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'b0, '0, '0);
    endtask

    function automatic vec_t mk(input logic r, input logic f, input logic [3:0] v,
                                input logic [3:0][5:0] rid, input logic [3:0][31:0] dat,
                                input logic [1:0] ev, input logic [5:0] r0, input logic [31:0] d0,
                                input logic [5:0] r1, input logic [31:0] d1);
        vec_t t;
        t.r = r; t.f = f; t.v = v; t.rid = rid; t.dat = dat;
        t.ev = ev; t.erid0 = r0; t.edat0 = d0; t.erid1 = r1; t.edat1 = d1;
        return t;
    endfunction

    initial begin
        logic [3:0][5:0]  rr_v;
        logic [3:0][31:0] dd_v;

        tbl[0] = mk(0, 0, 4'b0010, {6'd0, 6'd0, 6'd5, 6'd0}, {32'h0, 32'h0, 32'hAA, 32'h0},
                    2'b00, 6'd0, 32'h0, 6'd0, 32'h0);
        tbl[1] = mk(0, 0, 4'b0000, '0, '0, 2'b01, 6'd5, 32'hAA, 6'd0, 32'h0);
        tbl[2] = mk(0, 0, 4'b0000, '0, '0, 2'b00, 6'd0, 32'h0, 6'd0, 32'h0);
        tbl[3] = mk(0, 1, 4'b0000, '0, '0, 2'b00, 6'd0, 32'h0, 6'd0, 32'h0);
        tbl[4] = mk(0, 0, 4'b1111, {6'd4, 6'd3, 6'd2, 6'd1}, {32'h44, 32'h33, 32'h22, 32'h11},
                    2'b00, 6'd0, 32'h0, 6'd0, 32'h0);
        tbl[5] = mk(0, 0, 4'b0000, '0, '0, 2'b11, 6'd1, 32'h11, 6'd2, 32'h22);
        tbl[6] = mk(0, 0, 4'b0000, '0, '0, 2'b11, 6'd3, 32'h33, 6'd4, 32'h44);
        tbl[7] = mk(0, 0, 4'b0000, '0, '0, 2'b00, 6'd0, 32'h0, 6'd0, 32'h0);
        tbl[8] = mk(0, 0, 4'b1001, {6'd9, 6'd0, 6'd0, 6'd8}, {32'h99, 32'h0, 32'h0, 32'h88},
                    2'b00, 6'd0, 32'h0, 6'd0, 32'h0);
        tbl[9] = mk(0, 0, 4'b0000, '0, '0, 2'b11, 6'd8, 32'h88, 6'd9, 32'h99);

        rst = 1'b1; flush = 1'b0; src_valid_i = '0; src_rid_i = '0; src_data_i = '0;
        #1;
        step(1'b1, 1'b0, 4'b0, '0, '0);
        step(1'b1, 1'b0, 4'b0, '0, '0);
        check("reset_ready", 64'(src_ready_o), 64'hF);
        check("reset_rid", 64'(wkup_rid_o), 64'h0);

        // Table: single push latency, four-way contention, round-robin pointer return to 0.
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].r, tbl[i].f, tbl[i].v, tbl[i].rid, tbl[i].dat);
            check("tbl_valid", 64'(wkup_valid_o), 64'(tbl[i].ev));
            if (tbl[i].ev[0]) begin
                check("tbl_rid0", 64'(wkup_rid_o[0]), 64'(tbl[i].erid0));
                check("tbl_data0", 64'(wkup_data_o[0]), 64'(tbl[i].edat0));
            end
            if (tbl[i].ev[1]) begin
                check("tbl_rid1", 64'(wkup_rid_o[1]), 64'(tbl[i].erid1));
                check("tbl_data1", 64'(wkup_data_o[1]), 64'(tbl[i].edat1));
            end
        end

        // Single source streaming every cycle drains at one per cycle.
        for (int i = 0; i < 6; i++) begin
            rr_v = '0; dd_v = '0;
            rr_v[0] = 6'(20 + i); dd_v[0] = 32'(32'h200 + i);
            step(1'b0, 1'b0, 4'b0001, rr_v, dd_v);
            check("stream_ready0", 64'(src_ready_o[0]), 64'h1);
        end
        idle(); idle();

        // Fill FIFO2/3 under contention; ready stays low through the pop cycle.
        step(1'b0, 1'b1, 4'b0, '0, '0);
        step(1'b0, 1'b0, 4'b1111, {6'd33, 6'd32, 6'd31, 6'd30}, {32'h3, 32'h2, 32'h1, 32'h0});
        step(1'b0, 1'b0, 4'b1111, {6'd37, 6'd36, 6'd35, 6'd34}, {32'h7, 32'h6, 32'h5, 32'h4});
        check("ready_full", 64'(src_ready_o), 64'h3);
        for (int i = 0; i < 6; i++) begin
            rr_v = '0; dd_v = '0;
            rr_v[2] = 6'(40 + i); dd_v[2] = 32'(32'h400 + i);
            step(1'b0, 1'b0, 4'b0100, rr_v, dd_v);
        end
        for (int i = 0; i < 4; i++) idle();

        // Flush with three buffered results: none of them may ever appear.
        step(1'b0, 1'b0, 4'b0111, {6'd0, 6'd52, 6'd51, 6'd50}, {32'h0, 32'h52, 32'h51, 32'h50});
        step(1'b0, 1'b1, 4'b1111, {6'd56, 6'd55, 6'd54, 6'd53}, '0);
        for (int i = 0; i < 3; i++) begin
            idle();
            check("flush_valid", 64'(wkup_valid_o), 64'h0);
            check("flush_ready", 64'(src_ready_o), 64'hF);
        end

        // Reset together with flush and pushes mid-traffic.
        step(1'b0, 1'b0, 4'b1111, {6'd63, 6'd62, 6'd61, 6'd60}, {32'hD, 32'hC, 32'hB, 32'hA});
        step(1'b0, 1'b0, 4'b1111, {6'd59, 6'd58, 6'd57, 6'd56}, {32'h9, 32'h8, 32'h7, 32'h6});
        step(1'b1, 1'b1, 4'b1111, {6'd1, 6'd2, 6'd3, 6'd4}, {32'h1, 32'h2, 32'h3, 32'h4});
        check("rst_valid", 64'(wkup_valid_o), 64'h0);
        check("rst_rid", 64'(wkup_rid_o), 64'h0);
        check("rst_data", 64'(wkup_data_o), 64'h0);
        check("rst_ready", 64'(src_ready_o), 64'hF);
        for (int i = 0; i < 2; i++) begin
            idle();
            check("rst_quiet", 64'(wkup_valid_o), 64'h0);
        end

        // Randomized traffic against the model, with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            for (int s = 0; s < NS; s++) begin
                rr_v[s] = 6'($urandom_range(0, 63));
                dd_v[s] = $urandom;
            end
            step($urandom_range(0, 199) == 0, $urandom_range(0, 49) == 0,
                 4'($urandom), rr_v, dd_v);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
